if_weight_loader: RTL

Sequencer that loads synaptic weights into the `if_network` weight memory port from a host command plus data stream, optionally read-back verifying each word. It owns `mem_addr/mem_din/mem_wen` for the duration of a load and holds the network's neurons quiescent meanwhile. It sits between the host/DMA side and `if_network`.

---
 rtl/if_weight_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/if_weight_loader.sv
// Weight-memory load sequencer for if_network: streams host words into the
// weight port, optionally reading each one back and counting mismatches.
module if_weight_loader #(
  parameter int unsigned WEIGHT_SIZE = 32,
  parameter int unsigned NUM_LAYERS  = 1,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_layer,
  input  logic [27:0]            cmd_base,
  input  logic [27:0]            cmd_count,
  input  logic                   cmd_verify,
  input  logic                   wdata_valid,
  output logic                   wdata_ready,
  input  logic [WEIGHT_SIZE-1:0] wdata,
  output logic [31:0]            mem_addr,
  output logic [WEIGHT_SIZE-1:0] mem_din,
  output logic                   mem_wen,
  input  logic [WEIGHT_SIZE-1:0] mem_dout,
  output logic                   net_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   err_layer,
  output logic [15:0]            err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [2:0] WAIT_LAST = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  state_t                 state_q, state_d;
  logic [3:0]             layer_q, layer_d;
  logic [27:0]            idx_q, idx_d;
  logic [27:0]            rem_q, rem_d;
  logic                   verify_q, verify_d;
  logic [WEIGHT_SIZE-1:0] cmp_q, cmp_d;
  logic [31:0]            addr_q, addr_d;
  logic [WEIGHT_SIZE-1:0] din_q, din_d;
  logic                   wen_q, wen_d;
  logic                   err_layer_q, err_layer_d;
  logic [15:0]            err_cnt_q, err_cnt_d;
  logic [2:0]             wcnt_q, wcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      verify_q    <= 1'b0;
      cmp_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      wen_q       <= 1'b0;
      err_layer_q <= 1'b0;
      err_cnt_q   <= '0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      verify_q    <= verify_d;
      cmp_q       <= cmp_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wen_q       <= wen_d;
      err_layer_q <= err_layer_d;
      err_cnt_q   <= err_cnt_d;
      wcnt_q      <= wcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    verify_d    = verify_q;
    cmp_d       = cmp_q;
    addr_d      = addr_q;
    din_d       = din_q;
    wen_d       = 1'b0;
    err_layer_d = err_layer_q;
    err_cnt_d   = err_cnt_q;
    wcnt_d      = wcnt_q;
    wdata_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          layer_d     = cmd_layer;
          idx_d       = cmd_base;
          rem_d       = cmd_count;
          verify_d    = cmd_verify;
          err_cnt_d   = '0;
          err_layer_d = 1'b0;
          // Rejected and empty commands pass through WRITE with nothing left,
          // giving them the same one-cycle drain before DONE as a normal load.
          if ({28'd0, cmd_layer} >= NUM_LAYERS) begin
            err_layer_d = 1'b1;
            rem_d       = '0;
          end
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        wdata_ready = (rem_q != '0);
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else if (wdata_valid) begin
          addr_d = {layer_q, idx_q};
          din_d  = wdata;
          wen_d  = 1'b1;
          cmp_d  = wdata;
          idx_d  = idx_q + 28'd1;
          rem_d  = rem_q - 28'd1;
          if (verify_q) begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        wcnt_d  = '0;
        state_d = (RD_LAT > 1) ? S_WAIT : S_CHECK;
      end

      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = S_CHECK;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end

      S_CHECK: begin
        if ((mem_dout != cmp_q) && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
        state_d = (rem_q != '0) ? S_WRITE : S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign net_hold  = busy;
  assign done      = (state_q == S_DONE);
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign mem_wen   = wen_q;
  assign err_layer = err_layer_q;
  assign err_count = err_cnt_q;

endmodule
